// File: rtl/integ_step_ctrl.sv
// Integration-step sequencer: UM -> CD -> (VS -> UM -> CD)* -> writeback for one bot.
// Optional per-request watchdog is enabled by defining STEP_CTRL_TIMEOUT_EN.
module integ_step_ctrl #(
    parameter int unsigned W         = 16,
    parameter int unsigned FRAC      = 11,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TMO_CYC   = 255
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    input  logic [W-1:0] vx_in,
    input  logic [W-1:0] vy_in,
    output logic         um_in_rdy,
    output logic [W-1:0] um_vx,
    output logic [W-1:0] um_vy,
    input  logic         um_out_rdy,
    input  logic [W-1:0] um_x,
    input  logic [W-1:0] um_y,
    input  logic [W-1:0] um_vx_n,
    input  logic [W-1:0] um_vy_n,
    output logic         cd_in_rdy,
    output logic [W-1:0] cd_x,
    output logic [W-1:0] cd_y,
    output logic [W-1:0] cd_vx,
    output logic [W-1:0] cd_vy,
    input  logic         cd_out_rdy,
    input  logic         cd_trial,
    output logic         vs_in_rdy,
    output logic [W-1:0] vs_vx,
    output logic [W-1:0] vs_vy,
    input  logic         vs_out_rdy,
    input  logic [W-1:0] vs_vx_o,
    input  logic [W-1:0] vs_vy_o,
    output logic         wr_valid,
    output logic [W-1:0] wr_x,
    output logic [W-1:0] wr_y,
    output logic [W-1:0] wr_vx,
    output logic [W-1:0] wr_vy,
    output logic         busy,
    output logic         stalled,
    output logic         err_tmo
);

    localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        StIdle,
        StUmReq,
        StCdReq,
        StVsReq,
        StStop,
        StWrite
    } state_e;

    state_e state_q, state_d;

    logic [W-1:0]  base_x_q, base_y_q;
    logic [W-1:0]  vel_vx_q, vel_vy_q;
    logic [W-1:0]  cand_x_q, cand_y_q, cand_vx_q, cand_vy_q;
    logic [W-1:0]  wr_x_q, wr_y_q, wr_vx_q, wr_vy_q;
    logic [RW-1:0] retry_q;
    logic          stalled_q;
    logic          um_wait_q, cd_wait_q, vs_wait_q;

    logic um_req, cd_req, vs_req;
    logic um_done, cd_done, vs_done;
    logic start_step;
    logic tmo_hit;

    // A unit is only re-requested once its previous out_rdy has been seen low.
    assign um_req = (state_q == StUmReq) && !um_wait_q;
    assign cd_req = (state_q == StCdReq) && !cd_wait_q;
    assign vs_req = (state_q == StVsReq) && !vs_wait_q;

    assign um_done    = um_req && um_out_rdy;
    assign cd_done    = cd_req && cd_out_rdy;
    assign vs_done    = vs_req && vs_out_rdy;
    assign start_step = (state_q == StIdle) && start;

`ifdef STEP_CTRL_TIMEOUT_EN
    logic [7:0] wdog_q;
    logic       err_tmo_q;
    logic       in_req_state;

    assign in_req_state = (state_q == StUmReq) || (state_q == StCdReq) || (state_q == StVsReq);
    assign tmo_hit      = in_req_state && (wdog_q == 8'(TMO_CYC));

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wdog_q    <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                wdog_q <= '0;
            end else if (in_req_state) begin
                wdog_q <= wdog_q + 8'd1;
            end
            if (start_step) begin
                err_tmo_q <= 1'b0;
            end else if (tmo_hit) begin
                err_tmo_q <= 1'b1;
            end
        end
    end

    assign err_tmo = err_tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^32'(TMO_CYC);
    assign tmo_hit    = 1'b0;
    assign err_tmo    = 1'b0;
`endif

    logic unused_frac;
    assign unused_frac = ^32'(FRAC);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StUmReq;
            end
            StUmReq: begin
                if (um_done)      state_d = StCdReq;
                else if (tmo_hit) state_d = StIdle;
            end
            StCdReq: begin
                if (cd_done) begin
                    if (!cd_trial)                   state_d = StWrite;
                    else if (retry_q < RW'(MAX_RETRY)) state_d = StVsReq;
                    else                             state_d = StStop;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                end
            end
            StVsReq: begin
                if (vs_done)      state_d = StUmReq;
                else if (tmo_hit) state_d = StIdle;
            end
            StStop:  state_d = StWrite;
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            base_x_q  <= '0;
            base_y_q  <= '0;
            vel_vx_q  <= '0;
            vel_vy_q  <= '0;
            cand_x_q  <= '0;
            cand_y_q  <= '0;
            cand_vx_q <= '0;
            cand_vy_q <= '0;
            wr_x_q    <= '0;
            wr_y_q    <= '0;
            wr_vx_q   <= '0;
            wr_vy_q   <= '0;
            retry_q   <= '0;
            stalled_q <= 1'b0;
            um_wait_q <= 1'b0;
            cd_wait_q <= 1'b0;
            vs_wait_q <= 1'b0;
        end else begin
            if (start_step) begin
                base_x_q  <= x_in;
                base_y_q  <= y_in;
                vel_vx_q  <= vx_in;
                vel_vy_q  <= vy_in;
                retry_q   <= '0;
                stalled_q <= 1'b0;
            end
            if (um_done) begin
                cand_x_q  <= um_x;
                cand_y_q  <= um_y;
                cand_vx_q <= um_vx_n;
                cand_vy_q <= um_vy_n;
            end
            if (vs_done) begin
                vel_vx_q <= vs_vx_o;
                vel_vy_q <= vs_vy_o;
                retry_q  <= retry_q + RW'(1);
            end
            if (cd_done && !cd_trial) begin
                wr_x_q  <= cand_x_q;
                wr_y_q  <= cand_y_q;
                wr_vx_q <= cand_vx_q;
                wr_vy_q <= cand_vy_q;
            end
            if (state_q == StStop) begin
                wr_x_q    <= base_x_q;
                wr_y_q    <= base_y_q;
                wr_vx_q   <= '0;
                wr_vy_q   <= '0;
                stalled_q <= 1'b1;
            end
            um_wait_q <= um_done || (um_wait_q && um_out_rdy);
            cd_wait_q <= cd_done || (cd_wait_q && cd_out_rdy);
            vs_wait_q <= vs_done || (vs_wait_q && vs_out_rdy);
        end
    end

    // Request data is zeroed whenever the matching request is not asserted.
    assign um_in_rdy = um_req;
    assign um_vx     = um_req ? vel_vx_q : '0;
    assign um_vy     = um_req ? vel_vy_q : '0;
    assign cd_in_rdy = cd_req;
    assign cd_x      = cd_req ? cand_x_q : '0;
    assign cd_y      = cd_req ? cand_y_q : '0;
    assign cd_vx     = cd_req ? cand_vx_q : '0;
    assign cd_vy     = cd_req ? cand_vy_q : '0;
    assign vs_in_rdy = vs_req;
    assign vs_vx     = vs_req ? cand_vx_q : '0;
    assign vs_vy     = vs_req ? cand_vy_q : '0;

    assign wr_valid = (state_q == StWrite);
    assign wr_x     = wr_x_q;
    assign wr_y     = wr_y_q;
    assign wr_vx    = wr_vx_q;
    assign wr_vy    = wr_vy_q;
    assign busy     = (state_q != StIdle);
    assign stalled  = stalled_q;

endmodule
